pll_reset_sequencer: RTL and testbench

- Sequences the system PLL (50 MHz refclk in; 42 MHz, 3.652173 MHz and 7 MHz out) from power-up to a running system.
- Drives the PLL reset and qualifies its asynchronous `locked` signal.
- Releases the three output-clock-domain resets in a fixed staggered order.
- Recovers from lock loss with bounded retries.
- Sits at the top level between the PLL and the core. Runs entirely on refclk. Each downstream domain re-synchronises its own reset.

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync2.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAIT,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_e;

    localparam int unsigned DOM_42M = 0;
    localparam int unsigned DOM_3M6 = 1;
    localparam int unsigned DOM_7M  = 2;
    localparam int unsigned N_DOM   = 3;

    // Larger of two unsigned values, for sizing counters from parameters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the system PLL out of reset, qualifies lock, releases domain resets in order.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RELEASE_GAP   = 8,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               restart_req,
    output logic                               pll_rst,
    output logic [2:0]                         dom_rst,
    output logic                               ready,
    output logic                               fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int unsigned CNT_MAX = max_u(max_u(RST_CYCLES, LOCK_TIMEOUT),
                                            max_u(STABLE_CYCLES, 2*RELEASE_GAP + 1));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = $clog2(MAX_RETRY + 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     retry_d;
    logic              pll_rst_d;
    logic [2:0]        dom_rst_d;
    logic              ready_d;
    logic              fail_d;
    logic              lock_lost_d;
    logic              lk;

    // Bring the asynchronous PLL lock into the refclk domain.
    sync2 #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    // State, counter and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLLRST;
            cnt_q     <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            dom_rst   <= '1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            pll_rst   <= pll_rst_d;
            dom_rst   <= dom_rst_d;
            ready     <= ready_d;
            fail      <= fail_d;
            lock_lost <= lock_lost_d;
        end
    end

    // Next-state and next-output logic; restart beats lock loss beats normal sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_cnt;
        pll_rst_d   = pll_rst;
        dom_rst_d   = dom_rst;
        ready_d     = ready;
        fail_d      = fail;
        lock_lost_d = lock_lost;

        if (restart_req) begin
            state_d     = PLLRST;
            cnt_d       = '0;
            retry_d     = '0;
            pll_rst_d   = 1'b1;
            dom_rst_d   = '1;
            ready_d     = 1'b0;
            fail_d      = 1'b0;
            lock_lost_d = 1'b0;
        end else if ((state_q == RELEASE || state_q == RUN) && !lk) begin
            state_d     = PLLRST;
            cnt_d       = '0;
            retry_d     = '0;
            pll_rst_d   = 1'b1;
            dom_rst_d   = '1;
            ready_d     = 1'b0;
            lock_lost_d = 1'b1;
        end else begin
            case (state_q)
                PLLRST: begin
                    pll_rst_d = 1'b1;
                    dom_rst_d = '1;
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d   = WAIT;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    pll_rst_d = 1'b0;
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            state_d = PLLRST;
                            retry_d = retry_cnt + RW'(1);
                        end else begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d            = RELEASE;
                        cnt_d              = '0;
                        dom_rst_d[DOM_42M] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
                        dom_rst_d[DOM_3M6] = 1'b0;
                    end
                    if (cnt_q == CNT_W'(2*RELEASE_GAP - 1)) begin
                        dom_rst_d[DOM_7M] = 1'b0;
                    end
                    if (cnt_q == CNT_W'(2*RELEASE_GAP)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    ready_d   = 1'b1;
                    dom_rst_d = '0;
                end
                FAIL: begin
                    fail_d    = 1'b1;
                    pll_rst_d = 1'b1;
                    dom_rst_d = '1;
                end
                default: begin
                    state_d   = PLLRST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: stimulus queues expected output snapshots, a monitor checks every output change.
module tb_pll_reset_sequencer;

    typedef struct packed {
        logic       pll_rst;
        logic [2:0] dom;
        logic       ready;
        logic       fail;
        logic       lock_lost;
        logic [1:0] retry;
    } obs_t;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done = 0;
    obs_t  prev = 'x;

    int    exp_cyc[$];
    obs_t  exp_val[$];
    string exp_nm[$];

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .RELEASE_GAP   (3),
        .MAX_RETRY     (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .dom_rst     (dom_rst),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic pr, input logic [2:0] d, input logic r,
                                input logic f, input logic ll, input logic [1:0] rc);
        return {pr, d, r, f, ll, rc};
    endfunction

    task automatic expect_at(input int c, input obs_t v, input string nm);
        exp_cyc.push_back(c);
        exp_val.push_back(v);
        exp_nm.push_back(nm);
    endtask

    // Drive at 1 time unit after the posedge that makes cyc == c.
    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Monitor: every output change must match the next queued snapshot in value and cycle.
    always @(negedge refclk) begin
        obs_t  cur;
        obs_t  v;
        int    c;
        string nm;
        cur = {pll_rst, dom_rst, ready, fail, lock_lost, retry_cnt};
        if (cur !== prev) begin
            n_cmp = n_cmp + 1;
            if (exp_val.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_change: cyc=%0d got=%b", cyc, cur);
            end else begin
                c  = exp_cyc.pop_front();
                v  = exp_val.pop_front();
                nm = exp_nm.pop_front();
                if (c != cyc || v !== cur) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got cyc=%0d val=%b, need cyc=%0d val=%b", nm, cyc, cur, c, v);
                end
            end
            prev = cur;
        end
        if (done) begin
            while (exp_val.size() != 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                c  = exp_cyc.pop_front();
                v  = exp_val.pop_front();
                nm = exp_nm.pop_front();
                $display("FAIL %s: no change seen, need cyc=%0d val=%b", nm, c, v);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        restart_req = 1'b0;

        // Reset values, then nominal power-up.
        expect_at(1,  mk(1, 3'b111, 0, 0, 0, 0), "reset_state");
        expect_at(6,  mk(0, 3'b111, 0, 0, 0, 0), "nom_pll_rst_fall");
        expect_at(22, mk(0, 3'b110, 0, 0, 0, 0), "nom_rel_dom0");
        expect_at(25, mk(0, 3'b100, 0, 0, 0, 0), "nom_rel_dom1");
        expect_at(28, mk(0, 3'b000, 0, 0, 0, 0), "nom_rel_dom2");
        expect_at(29, mk(0, 3'b000, 1, 0, 0, 0), "nom_ready");
        at_cyc(2);  rst_n = 1'b1;
        at_cyc(11); pll_locked = 1'b1;

        // Lock drops in RUN, full re-sequence with lock_lost sticky.
        expect_at(35, mk(1, 3'b111, 0, 0, 1, 0), "loss_reset");
        expect_at(39, mk(0, 3'b111, 0, 0, 1, 0), "loss_pll_rst_fall");
        expect_at(55, mk(0, 3'b110, 0, 0, 1, 0), "loss_rel_dom0");
        expect_at(58, mk(0, 3'b100, 0, 0, 1, 0), "loss_rel_dom1");
        expect_at(61, mk(0, 3'b000, 0, 0, 1, 0), "loss_rel_dom2");
        expect_at(62, mk(0, 3'b000, 1, 0, 1, 0), "loss_ready");
        at_cyc(32); pll_locked = 1'b0;
        at_cyc(44); pll_locked = 1'b1;

        // Restart coincident with lock loss, then a glitchy lock.
        expect_at(68,  mk(1, 3'b111, 0, 0, 0, 0), "restart_beats_loss");
        expect_at(72,  mk(0, 3'b111, 0, 0, 0, 0), "glitch_pll_rst_fall");
        expect_at(94,  mk(0, 3'b110, 0, 0, 0, 0), "glitch_rel_dom0");
        expect_at(97,  mk(0, 3'b100, 0, 0, 0, 0), "glitch_rel_dom1");
        expect_at(100, mk(0, 3'b000, 0, 0, 0, 0), "glitch_rel_dom2");
        expect_at(101, mk(0, 3'b000, 1, 0, 0, 0), "glitch_ready");
        at_cyc(65); pll_locked = 1'b0;
        at_cyc(67); restart_req = 1'b1;
        at_cyc(68); restart_req = 1'b0;
        at_cyc(77); pll_locked = 1'b1;
        at_cyc(82); pll_locked = 1'b0;
        at_cyc(83); pll_locked = 1'b1;

        // Lock never asserts: two retries then the terminal state, then restart.
        expect_at(105, mk(1, 3'b111, 0, 0, 0, 0), "nolock_restart");
        expect_at(109, mk(0, 3'b111, 0, 0, 0, 0), "nolock_wait0");
        expect_at(129, mk(1, 3'b111, 0, 0, 0, 1), "nolock_retry1");
        expect_at(133, mk(0, 3'b111, 0, 0, 0, 1), "nolock_wait1");
        expect_at(153, mk(1, 3'b111, 0, 0, 0, 2), "nolock_retry2");
        expect_at(157, mk(0, 3'b111, 0, 0, 0, 2), "nolock_wait2");
        expect_at(177, mk(1, 3'b111, 0, 1, 0, 2), "nolock_exhausted");
        expect_at(183, mk(1, 3'b111, 0, 0, 0, 0), "exhausted_restart");
        expect_at(187, mk(0, 3'b111, 0, 0, 0, 0), "restart_pll_rst_fall");
        expect_at(203, mk(0, 3'b110, 0, 0, 0, 0), "midrel_dom0");
        expect_at(206, mk(0, 3'b100, 0, 0, 0, 0), "midrel_dom1");
        at_cyc(104); pll_locked = 1'b0; restart_req = 1'b1;
        at_cyc(105); restart_req = 1'b0;
        at_cyc(182); restart_req = 1'b1;
        at_cyc(183); restart_req = 1'b0;
        at_cyc(192); pll_locked = 1'b1;

        // Async reset mid-RELEASE, then recovery with lock already present.
        expect_at(207, mk(1, 3'b111, 0, 0, 0, 0), "async_reset");
        expect_at(214, mk(0, 3'b111, 0, 0, 0, 0), "post_rst_pll_rst_fall");
        expect_at(223, mk(0, 3'b110, 0, 0, 0, 0), "post_rst_dom0");
        expect_at(226, mk(0, 3'b100, 0, 0, 0, 0), "post_rst_dom1");
        expect_at(229, mk(0, 3'b000, 0, 0, 0, 0), "post_rst_dom2");
        expect_at(230, mk(0, 3'b000, 1, 0, 0, 0), "post_rst_ready");
        at_cyc(207); rst_n = 1'b0;
        at_cyc(210); rst_n = 1'b1;

        at_cyc(236); done = 1'b1;
    end

endmodule
